// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path (controller, refill engine, L1 arrays).
// Geometry localparams describe the default 64-set, 64-byte-line configuration.
package icache_pkg;

  localparam int S_DEF    = 64;
  localparam int B_DEF    = 64;
  localparam int WORDS    = B_DEF / 4;
  localparam int OFFSET_W = $clog2(B_DEF);
  localparam int INDEX_W  = $clog2(S_DEF);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int WORD_W   = $clog2(WORDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } refill_state_t;

endpackage

// File: rtl/icache_refill_unit.sv
// L1 instruction-cache refill engine: one burst read per miss, beats streamed into the L1 arrays.
// A redirect aborts the fill but the remaining beats are always drained.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for an accepted miss
// ST_REQ   | burst request presented, waiting for mem_req_ready_i
// ST_RECV  | writing returned beats into L1
// ST_DRAIN | fill aborted, swallowing the remaining beats without writes
// ST_DONE  | one-cycle completion pulse
module icache_refill_unit
  import icache_pkg::*;
#(
  parameter int S = S_DEF,
  parameter int B = B_DEF
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               miss_f_i,
  input  logic                               rep_active_i,
  input  logic                               redirect_i,
  input  logic [31:0]                        pc_f_i,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic [31:0]                        mem_req_addr_o,
  input  logic                               mem_rsp_valid_i,
  input  logic [31:0]                        mem_rsp_data_i,
  output logic                               fill_we_o,
  output logic [$clog2(S)-1:0]               fill_set_o,
  output logic [$clog2(B/4)-1:0]             fill_word_o,
  output logic [31:0]                        fill_data_o,
  output logic [32-$clog2(S)-$clog2(B)-1:0]  fill_tag_o,
  output logic                               fill_done_o,
  output logic                               busy_o
);

  localparam int          N_WORDS = B / 4;
  localparam int          OFF_W   = $clog2(B);
  localparam int          IDX_W   = $clog2(S);
  localparam int          TG_W    = 32 - IDX_W - OFF_W;
  localparam int          CNT_W   = $clog2(N_WORDS);
  localparam logic [31:0] LINE_MASK = ~(32'(B) - 32'd1);

  refill_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        line_q, line_d;
  logic               last_beat;

  assign last_beat = (cnt_q == CNT_W'(N_WORDS - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    line_d          = line_q;
    mem_req_valid_o = 1'b0;
    fill_we_o       = 1'b0;
    fill_done_o     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_f_i && rep_active_i && !redirect_i) begin
          state_d = ST_REQ;
          line_d  = pc_f_i & LINE_MASK;
        end
      end

      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          // The burst is committed once accepted, so a redirect here still has to drain it.
          cnt_d   = '0;
          state_d = redirect_i ? ST_DRAIN : ST_RECV;
        end else if (redirect_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_RECV: begin
        if (mem_rsp_valid_i) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (redirect_i) begin
            state_d = last_beat ? ST_IDLE : ST_DRAIN;
          end else begin
            fill_we_o = 1'b1;
            if (last_beat) state_d = ST_DONE;
          end
        end else if (redirect_i) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (mem_rsp_valid_i) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        fill_done_o = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign mem_req_addr_o = line_q;
  assign fill_set_o     = line_q[OFF_W +: IDX_W];
  assign fill_tag_o     = line_q[31 -: TG_W];
  assign fill_word_o    = cnt_q;
  assign fill_data_o    = fill_we_o ? mem_rsp_data_i : 32'd0;

endmodule
